// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe - writeback-control pipeline.
//
// Decodes the destination register and write enable of each issued
// instruction, then delays them through STAGES registered stages so the
// register-file write lines up with the result. Every valid entry that
// writes marks its destination register pending in a scoreboard, which
// the decode stage queries for hazards.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   issue_valid          instruction presented this cycle
//   op1, op3             major opcode / ALU function fields
//   Rd_Rb, Ra_op2        register fields used to decode the destination
//   stall, flush         freeze / kill in-flight entries (flush wins)
//   src_a, src_b         decode-stage source registers for hazard query
//   write_add            register-file write address (writeback stage)
//   writeOrder           register-file write enable
//   busy                 per-register pending-write scoreboard
//   hazard_a, hazard_b   busy[src_a], busy[src_b]
//   pending_cnt          number of valid in-flight entries (registered)
module wb_ctrl_pipe #(
  parameter int REG_ADDR_W = 3,
  parameter int STAGES     = 3,
  parameter int CNT_W      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [1:0]                op1,
  input  logic [3:0]                op3,
  input  logic [REG_ADDR_W-1:0]     Rd_Rb,
  input  logic [REG_ADDR_W-1:0]     Ra_op2,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [REG_ADDR_W-1:0]     src_a,
  input  logic [REG_ADDR_W-1:0]     src_b,
  output logic [REG_ADDR_W-1:0]     write_add,
  output logic                      writeOrder,
  output logic [(2**REG_ADDR_W)-1:0] busy,
  output logic                      hazard_a,
  output logic                      hazard_b,
  output logic [CNT_W-1:0]          pending_cnt
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int LAST     = STAGES - 1;

  logic [STAGES-1:0]     r_v;
  logic [STAGES-1:0]     r_we;
  logic [REG_ADDR_W-1:0] r_addr [STAGES];
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_dec_we;
  logic [REG_ADDR_W-1:0] w_dec_addr;
  logic [STAGES-1:0]     w_v_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [NUM_REGS-1:0]   w_busy;

  // Instruction decode
  always_comb begin
    w_dec_we   = 1'b0;
    w_dec_addr = Rd_Rb;
    case (op1)
      2'd0: begin
        w_dec_we   = 1'b1;
        w_dec_addr = Ra_op2;
      end
      2'd1: w_dec_we = 1'b0;
      2'd2: w_dec_we = (Ra_op2 == '0);
      default: begin
        case (op3)
          4'd7, 4'd13, 4'd14, 4'd15: w_dec_we = 1'b0;
          default:                   w_dec_we = 1'b1;
        endcase
      end
    endcase
  end

  // Next valid vector; pending_cnt is computed from it so the count is
  // registered on the same edge as the stages.
  always_comb begin
    w_v_next = r_v;
    if (flush) begin
      w_v_next = '0;
    end else if (!stall) begin
      w_v_next[0] = issue_valid;
      for (int i = 1; i < STAGES; i++) begin
        w_v_next[i] = r_v[i-1];
      end
    end
  end

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_cnt_next = w_cnt_next + CNT_W'(w_v_next[i]);
    end
  end

  // Stage registers. On flush only the valid bits clear; we/addr of dead
  // entries are don't-care since every consumer qualifies them with v.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v   <= '0;
      r_we  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_v   <= w_v_next;
      r_cnt <= w_cnt_next;
      if (!flush && !stall) begin
        r_we[0]   <= w_dec_we;
        r_addr[0] <= w_dec_addr;
        for (int i = 1; i < STAGES; i++) begin
          r_we[i]   <= r_we[i-1];
          r_addr[i] <= r_addr[i-1];
        end
      end
    end
  end

  // Scoreboard includes the writeback stage: the register is still pending
  // until its write has actually happened.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (r_v[i] && r_we[i]) begin
        w_busy[r_addr[i]] = 1'b1;
      end
    end
  end

  assign busy        = w_busy;
  assign hazard_a    = w_busy[src_a];
  assign hazard_b    = w_busy[src_b];
  assign write_add   = r_addr[LAST];
  // A frozen writeback entry must write only once, on its first free cycle.
  assign writeOrder  = r_v[LAST] & r_we[LAST] & ~stall;
  assign pending_cnt = r_cnt;

endmodule
